// File: rtl/ewrapper_io_rx_deser.sv
// ----------------------------------------------------------------------------
// ewrapper_io_rx_deser
//
// Receive-side deserializer for a 9-lane eLink. Each fast clock delivers one
// DDR pair per lane: an even (first-in-time) bit and an odd (second-in-time)
// bit. Lane 8 carries the frame signal and lanes 0-7 carry data. Four
// consecutive pairs (slots 0-3) form one 72-bit word. Byte j of the word comes
// from lane j, MSB first, so this block is the exact inverse of the TX
// serializer.
//
// A rising frame seen on an even bit marks slot 0 and establishes lock. After
// lock, every slot 3 completes a word. A rising frame seen on an odd bit (a
// half-cycle slip), or an even-bit rise that arrives away from slot 0, pulses
// ALIGN_ERR. Only the even-bit case re-aligns the slot counter.
//
// Pipeline: inputs are registered in stage p0. The slot decode and word
// assembly happen in stage p1. The finished word is presented in stage p2.
// A slot-0 pair sampled at edge E gives DATA_VALID high after edge E+5.
//
// Parameters
//   ELINK_INVERT        1 = invert all 18 input bits before use (E64 polarity)
// Ports
//   CLK_IN              fast link clock; all state updates on its rising edge
//   IO_RESET            asynchronous, active-high reset
//   DATA_EVEN_IN[8:0]   first-in-time bit per lane (lane 8 = frame)
//   DATA_ODD_IN[8:0]    second-in-time bit per lane
//   DATA_OUT_TO_DEVICE  deserialized word; byte j holds bits 8j+7..8j, from lane j
//   DATA_VALID          one-cycle strobe; DATA_OUT_TO_DEVICE was updated this cycle
//   FRAME_LOCK          word boundary established; cleared only by reset
//   ALIGN_ERR           one-cycle pulse on an alignment fault
// ----------------------------------------------------------------------------
module ewrapper_io_rx_deser #(
    parameter bit ELINK_INVERT = 1'b0
) (
    input  logic        CLK_IN,
    input  logic        IO_RESET,
    input  logic [8:0]  DATA_EVEN_IN,
    input  logic [8:0]  DATA_ODD_IN,
    output logic [71:0] DATA_OUT_TO_DEVICE,
    output logic        DATA_VALID,
    output logic        FRAME_LOCK,
    output logic        ALIGN_ERR
);

    logic [8:0]  even_in;
    logic [8:0]  odd_in;
    logic [8:0]  even_p0;
    logic [8:0]  odd_p0;
    logic        prev_frame_p1;
    logic [1:0]  slot_p1;
    logic [71:0] asm_p1;
    logic        done_p1;
    logic        lock_q;

    logic        even_rise;
    logic        odd_rise;
    logic [1:0]  slot_inc;
    logic [1:0]  slot_nxt;
    logic        misalign;
    logic [71:0] asm_nxt;

    assign even_in    = ELINK_INVERT ? ~DATA_EVEN_IN : DATA_EVEN_IN;
    assign odd_in     = ELINK_INVERT ? ~DATA_ODD_IN  : DATA_ODD_IN;
    assign FRAME_LOCK = lock_q;

    // ---- stage p0: capture the (polarity-corrected) DDR pair ----
    always_ff @(posedge CLK_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            even_p0 <= '0;
            odd_p0  <= '0;
        end else begin
            even_p0 <= even_in;
            odd_p0  <= odd_in;
        end
    end

    // Frame decode and slot steering of the registered pair
    always_comb begin
        even_rise = ~prev_frame_p1 & even_p0[8];
        odd_rise  = ~prev_frame_p1 & ~even_p0[8] & odd_p0[8];
        slot_inc  = slot_p1 + 2'd1;
        slot_nxt  = even_rise ? 2'd0 : slot_inc;
        // An even-bit rise after lock is only expected when the counter would
        // wrap to slot 0 by itself.
        misalign  = odd_rise | (even_rise & lock_q & (slot_inc != 2'd0));
        asm_nxt   = asm_p1;
        for (int k = 0; k < 4; k++) begin
            if (slot_nxt == 2'(k)) begin
                for (int j = 0; j < 9; j++) begin
                    asm_nxt[8*j + 7 - 2*k] = even_p0[j];
                    asm_nxt[8*j + 6 - 2*k] = odd_p0[j];
                end
            end
        end
    end

    // ---- stage p1: slot tracking, lock and word assembly ----
    always_ff @(posedge CLK_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            prev_frame_p1 <= 1'b0;
            slot_p1       <= 2'd0;
            asm_p1        <= '0;
            done_p1       <= 1'b0;
            lock_q        <= 1'b0;
            ALIGN_ERR     <= 1'b0;
        end else begin
            prev_frame_p1 <= odd_p0[8];
            slot_p1       <= slot_nxt;
            asm_p1        <= asm_nxt;
            // A restart at slot 0 never reaches slot 3 with the old partial
            // word, so dropping a partial word needs no extra state.
            done_p1       <= lock_q & (slot_nxt == 2'd3);
            lock_q        <= lock_q | even_rise;
            ALIGN_ERR     <= misalign;
        end
    end

    // ---- stage p2: present the completed word ----
    always_ff @(posedge CLK_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            DATA_OUT_TO_DEVICE <= '0;
            DATA_VALID         <= 1'b0;
        end else begin
            DATA_VALID <= done_p1;
            if (done_p1) begin
                DATA_OUT_TO_DEVICE <= asm_p1;
            end
        end
    end

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
module tb_ewrapper_io_rx_deser;

    logic        clk;
    logic        rst;
    logic [8:0]  even_d;
    logic [8:0]  odd_d;
    logic [8:0]  even_n;
    logic [8:0]  odd_n;
    logic [71:0] dout;
    logic        dvalid;
    logic        lock;
    logic        aerr;
    logic [71:0] dout_i;
    logic        dvalid_i;
    logic        lock_i;
    logic        aerr_i;

    // Normal-polarity DUT
    ewrapper_io_rx_deser #(.ELINK_INVERT(1'b0)) dut (
        .CLK_IN(clk), .IO_RESET(rst),
        .DATA_EVEN_IN(even_d), .DATA_ODD_IN(odd_d),
        .DATA_OUT_TO_DEVICE(dout), .DATA_VALID(dvalid),
        .FRAME_LOCK(lock), .ALIGN_ERR(aerr)
    );

    // Inverted-polarity DUT fed the complemented stimulus
    assign even_n = ~even_d;
    assign odd_n  = ~odd_d;
    ewrapper_io_rx_deser #(.ELINK_INVERT(1'b1)) dut_inv (
        .CLK_IN(clk), .IO_RESET(rst),
        .DATA_EVEN_IN(even_n), .DATA_ODD_IN(odd_n),
        .DATA_OUT_TO_DEVICE(dout_i), .DATA_VALID(dvalid_i),
        .FRAME_LOCK(lock_i), .ALIGN_ERR(aerr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          edge_n = 0;
    int          passes = 0;
    int          total  = 0;
    logic [71:0] obs_w[$];
    int          obs_t[$];
    logic [71:0] obs_wi[$];
    int          obs_ti[$];
    int          al_t[$];
    int          al_ti[$];
    logic [71:0] exp_w[$];
    int          exp_t[$];
    int          exp_al[$];

    // Log strobes away from the active edge
    always @(negedge clk) begin
        if (dvalid)   begin obs_w.push_back(dout);    obs_t.push_back(edge_n);  end
        if (dvalid_i) begin obs_wi.push_back(dout_i); obs_ti.push_back(edge_n); end
        if (aerr)     al_t.push_back(edge_n);
        if (aerr_i)   al_ti.push_back(edge_n);
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Serialize the first n slots of word w, MSB first per lane; e = edge of slot 0
    task automatic send(input logic [71:0] w, input int n, output int e);
        e = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 9; j++) begin
                even_d[j] = w[8*j + 7 - 2*k];
                odd_d[j]  = w[8*j + 6 - 2*k];
            end
            cyc();
            if (k == 0) e = edge_n;
        end
    endtask

    logic [71:0] wl[9];
    int          e;
    int          n_before;

    initial begin
        wl[0] = 72'hFF_0807060504030201;
        wl[1] = 72'hFF_0123456789ABCDEF;
        wl[2] = 72'hFF_FEDCBA9876543210;
        wl[3] = 72'hFF_0000000000000000;
        wl[4] = 72'hFF_FFFFFFFFFFFFFFFF;
        wl[5] = 72'hFF_AAAAAAAAAAAAAAAA;
        wl[6] = 72'hFF_5555555555555555;
        wl[7] = 72'hFF_8000000000000001;
        wl[8] = 72'hFF_DEADBEEFCAFEF00D;

        rst = 1'b1; even_d = '0; odd_d = '0;
        repeat (2) cyc();
        check("rst_dout",   dout,   72'h0);
        check("rst_valid",  {71'h0, dvalid}, 72'h0);
        check("rst_lock",   {71'h0, lock},   72'h0);
        check("rst_aerr",   {71'h0, aerr},   72'h0);
        check("rst_dout_inv", dout_i, 72'h0);
        rst = 1'b0;

        // Idle, frame low; the inverted DUT sees a constant-high bus
        repeat (5) cyc();
        check("idle_lock",     {71'h0, lock},   72'h0);
        check("idle_lock_inv", {71'h0, lock_i}, 72'h0);
        check("idle_nvalid",   72'(obs_w.size()), 72'd0);

        // First word with even-rise, then 8 more with frame held high
        send(wl[0], 4, e);
        exp_w.push_back(wl[0]); exp_t.push_back(e + 5);
        check("lock_set",     {71'h0, lock},   72'h1);
        check("lock_set_inv", {71'h0, lock_i}, 72'h1);
        for (int i = 1; i < 9; i++) begin
            send(wl[i], 4, e);
            exp_w.push_back(wl[i]); exp_t.push_back(e + 5);
        end
        check("burst_aerr_cnt", 72'(al_t.size()), 72'd0);

        // Frame falls after slot 1, then an even-rise arrives at slot 2
        send(72'hE0_1111111111111111, 2, e);
        send(72'hFF_2468ACE013579BDF, 4, e);
        exp_w.push_back(72'hFF_2468ACE013579BDF); exp_t.push_back(e + 5);
        exp_al.push_back(e + 1);

        // Frame byte 0x9F rises on the odd bit of slot 1 only
        send(72'h9F_0F1E2D3C4B5A6978, 4, e);
        exp_w.push_back(72'h9F_0F1E2D3C4B5A6978); exp_t.push_back(e + 5);
        exp_al.push_back(e + 2);
        check("odd_rise_lock", {71'h0, lock}, 72'h1);

        // Reset in the middle of a word, while the previous word is on the output
        send(72'hFF_7766554433221100, 2, e);
        check("pre_rst_valid", {71'h0, dvalid}, 72'h1);
        check("pre_rst_dout",  dout, 72'h9F_0F1E2D3C4B5A6978);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_dout",  dout,   72'h0);
        check("mid_rst_valid", {71'h0, dvalid}, 72'h0);
        check("mid_rst_lock",  {71'h0, lock},   72'h0);
        check("mid_rst_aerr",  {71'h0, aerr},   72'h0);
        even_d = '0; odd_d = '0;
        repeat (2) cyc();
        rst = 1'b0;
        n_before = obs_w.size();
        repeat (8) cyc();
        check("post_rst_nvalid", 72'(obs_w.size()), 72'(n_before));
        check("post_rst_lock",   {71'h0, lock}, 72'h0);
        send(72'hFF_C3C3A5A5_3C3C5A5A, 4, e);
        exp_w.push_back(72'hFF_C3C3A5A5_3C3C5A5A); exp_t.push_back(e + 5);
        even_d = '0; odd_d = '0;
        repeat (3) cyc();

        // Compare every logged strobe and alignment pulse with expectations
        check("nwords",     72'(obs_w.size()),  72'(exp_w.size()));
        check("nwords_inv", 72'(obs_wi.size()), 72'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            check($sformatf("word%0d", i), (i < obs_w.size()) ? obs_w[i] : 72'hX, exp_w[i]);
            check($sformatf("time%0d", i), (i < obs_t.size()) ? 72'(obs_t[i]) : 72'hX, 72'(exp_t[i]));
            check($sformatf("word%0d_inv", i), (i < obs_wi.size()) ? obs_wi[i] : 72'hX, exp_w[i]);
            check($sformatf("time%0d_inv", i), (i < obs_ti.size()) ? 72'(obs_ti[i]) : 72'hX, 72'(exp_t[i]));
        end
        check("naerr",     72'(al_t.size()),  72'(exp_al.size()));
        check("naerr_inv", 72'(al_ti.size()), 72'(exp_al.size()));
        for (int i = 0; i < exp_al.size(); i++) begin
            check($sformatf("aerr%0d", i), (i < al_t.size()) ? 72'(al_t[i]) : 72'hX, 72'(exp_al[i]));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
